alu_sequencer: RTL and testbench
================================

# alu_sequencer

Hard-wired control unit for the phase-1 CPU datapath. It walks the datapath through instruction fetch (T0–T2) and the execute steps (T3–T6) of register-register ALU, multiply and divide instructions. It drives every datapath strobe that is otherwise hand-toggled per state, so one controller replaces per-instruction stimulus sequencing. It sits beside `datapath`, reads the IR contents back from it, and holds off fetch on a memory-ready handshake.

## Interface
Parameters:
- `NREGS`, 16: number of general registers; width of the one-hot select buses.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clock`  in  1: the only clock; all state changes on its rising edge.
- `clear`  in  1: reset, synchronous, active-high.
- `run`  in  1: when high, the sequencer fetches and executes instructions.
- `ir`  in  32: IR contents from the datapath. Fields: opcode `ir[31:27]`, Ra `ir[26:23]`, Rb `ir[22:19]`, Rc `ir[18:15]`.
- `mem_ready`  in  1: memory data is valid on Mdatain this cycle.
- `PCout`, `MARin`, `IncPC`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `ZLowIn`, `ZHighIn`, `ZLowOut`, `ZHighOut`, `LOin`, `HIin`  out  1 each: datapath strobes.
- `Rout`  out  NREGS: one-hot register-to-bus enable.
- `Rin`  out  NREGS: one-hot register load enable.
- `alu_op`  out  5: ALU function select. Equals the opcode during T4 and is 0 otherwise.
- `busy`  out  1: high in every state except IDLE and HALTED.
- `halted`  out  1: high in HALTED.
- `illegal`  out  1: one-cycle pulse when an unsupported opcode is decoded.
- `instr_count`  out  CNT_W: count of retired instructions.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED.
- Outputs are Moore outputs, decoded from the registered state and `ir`. Every strobe is high for exactly the whole cycle of its state.
- IDLE: all strobes 0. Moves to T0 when `run`=1.
- T0: `PCout`, `MARin`, `IncPC`. The PC increments internally.
- T1: `Read`, `MDRin`. Stays in T1 while `mem_ready`=0; moves to T2 on the first cycle with `mem_ready`=1.
- T2: `MDRout`, `IRin`. The IR loads at the end of T2. Decode uses `ir` from T3 onward.
- Opcodes:
  - ALU class: add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, neg 01001, not 01010.
  - mul 01111, div 10000, nop 11010, halt 11011.
- ALU class:
  - T3: `Rout[Rb]`, `Yin`.
  - T4: `Rout[Rc]`, `ZLowIn`, `alu_op`.
  - T5: `ZLowOut`, `Rin[Ra]`. This retires the instruction.
- mul/div:
  - T3: as the ALU class.
  - T4: adds `ZHighIn` to the ALU-class strobes.
  - T5: `ZLowOut`, `LOin`.
  - T6: `ZHighOut`, `HIin`. This retires the instruction.
- nop: retires in T3 with no strobes.
- halt: in T3, goes to HALTED. HALTED is left only by `clear`.
- Unsupported opcode: in T3, pulses `illegal`, asserts no strobes, and counts as retired.
- At retire: `instr_count` increments, wrapping modulo 2^CNT_W. Next state is T0 if `run`=1, otherwise IDLE. `run` is sampled only at retire and in IDLE.
- Register select: `Rout` and `Rin` are each all-zero or exactly one-hot, and never both nonzero in the same cycle.

## Timing
- `clear`=1 at an edge forces IDLE, all outputs 0 and `instr_count` 0 after that edge. This holds in any state, including mid-T1 wait and HALTED.
- When `clear` and `run` are both 1, `clear` wins.
- Latency, with `mem_ready` tied high:
  - ALU class: 6 cycles, T0–T5.
  - mul/div: 7 cycles.
  - nop: 4 cycles.
- Each cycle of `mem_ready`=0 in T1 adds one cycle.
- Back-to-back instructions: T0 directly follows the retiring state, with no bubble.
- `illegal` is high only during the T3 cycle.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - opcode constants;
  - the state enum;
  - IR field bit positions.
- The datapath and the bench import this package.
- Sub-module `reg_select_decoder`: 4-bit index plus enable in, NREGS one-hot out. It is instantiated twice, once for `Rout` and once for `Rin`.

## Test plan
- and R4,R3,R7: reset, `run`=1, `ir`=0x2A1B8000, `mem_ready`=1.
  - T3: `Rout`=0x0008, `Yin`=1.
  - T4: `Rout`=0x0080, `ZLowIn`=1, `alu_op`=00101.
  - T5: `ZLowOut`=1, `Rin`=0x0010.
  - `instr_count` goes 0→1 after 6 cycles.
- mul R2,R6: `ir`=0x78130000.
  - T4: `ZLowIn`=`ZHighIn`=1.
  - T5: `LOin`=1.
  - T6: `ZHighOut`=1, `HIin`=1.
  - Retires in 7 cycles.
- Memory wait: `mem_ready` low for 3 cycles in T1. `Read`=`MDRin`=1 for 4 cycles, then T2. Instruction total is 9 cycles.
- halt then `run` toggling: `ir` with opcode 11011 leads to `halted`=1 and `busy`=0. The block stays halted until `clear`, then IDLE.
- Reset mid-operation: `clear` pulsed during T4. Next cycle all strobes are 0, `instr_count`=0 and the state is IDLE. With `run` high it restarts at T0.
- Illegal opcode 11111: `illegal` pulses for 1 cycle in T3 with no strobes. `instr_count` increments and fetch resumes at T0. A one-hot checker passes on every cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the phase-1 CPU: opcode encodings, IR field
// positions, the sequencer state encoding and an opcode classifier.
// No ports; imported by the sequencer, the datapath and the bench.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_NEG  = 5'b01001;
    localparam logic [4:0] OP_NOT  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int IR_OPC_HI = 31;
    localparam int IR_OPC_LO = 27;
    localparam int IR_RA_HI  = 26;
    localparam int IR_RA_LO  = 23;
    localparam int IR_RB_HI  = 22;
    localparam int IR_RB_LO  = 19;
    localparam int IR_RC_HI  = 18;
    localparam int IR_RC_LO  = 15;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_MULDIV,
        CL_NOP,
        CL_HALT,
        CL_ILLEGAL
    } op_class_e;

    function automatic op_class_e classify(input logic [4:0] op);
        op_class_e cl;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_NEG, OP_NOT: cl = CL_ALU;
            OP_MUL, OP_DIV:                 cl = CL_MULDIV;
            OP_NOP:                         cl = CL_NOP;
            OP_HALT:                        cl = CL_HALT;
            default:                        cl = CL_ILLEGAL;
        endcase
        return cl;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// One-hot general-register select.
// Ports:
//   idx_i    in  4      register index
//   en_i     in  1      enable; output is all-zero when low
//   onehot_o out NREGS  one-hot select (all-zero if idx_i >= NREGS)
module reg_select_decoder #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       idx_i,
    input  logic             en_i,
    output logic [NREGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NREGS; i++) begin
            onehot_o[i] = en_i && (int'(idx_i) == i);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Hard-wired control unit for the phase-1 datapath: instruction fetch (T0-T2)
// and execute (T3-T6) for ALU, mul/div, nop and halt instructions.
// Ports:
//   clock, clear      clock and synchronous active-high reset
//   run               start / continue fetching (sampled in IDLE and at retire)
//   ir[31:0]          IR contents read back from the datapath
//   mem_ready         memory data valid; releases the T1 wait
//   PCout..HIin       datapath strobes
//   Rout, Rin         one-hot register bus enable / load enable
//   alu_op            opcode during T4, else 0
//   busy, halted      status
//   illegal           one-cycle pulse in T3 for an unsupported opcode
//   instr_count       retired-instruction count, wraps
//
//   state   | meaning
//   IDLE    | waiting for run, all strobes low
//   T0      | PC to MAR, PC increment
//   T1      | memory read; held here until mem_ready
//   T2      | MDR to IR
//   T3      | decode; Rb to Y, or retire nop/illegal, or enter HALTED
//   T4      | Rc through ALU into Z
//   T5      | Z low to Ra (ALU class, retire) or to LO (mul/div)
//   T6      | Z high to HI (mul/div, retire)
//   HALTED  | stopped until clear
module alu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             ZLowIn,
    output logic             ZHighIn,
    output logic             ZLowOut,
    output logic             ZHighOut,
    output logic             LOin,
    output logic             HIin,
    output logic [NREGS-1:0] Rout,
    output logic [NREGS-1:0] Rin,
    output logic [4:0]       alu_op,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    logic [4:0]       opcode;
    logic [3:0]       ra, rb, rc;
    op_class_e        op_class;
    logic             is_muldiv;
    logic             rout_en, rin_en;
    logic [3:0]       rout_idx;
    logic             unused_ir_bits;

    assign opcode         = ir[IR_OPC_HI:IR_OPC_LO];
    assign ra             = ir[IR_RA_HI:IR_RA_LO];
    assign rb             = ir[IR_RB_HI:IR_RB_LO];
    assign rc             = ir[IR_RC_HI:IR_RC_LO];
    assign unused_ir_bits = ^ir[IR_RC_LO-1:0];
    assign op_class       = classify(opcode);
    assign is_muldiv      = (op_class == CL_MULDIV);

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (mem_ready) state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (op_class == CL_ALU || is_muldiv) state_d = ST_T4;
                else if (op_class == CL_HALT)        state_d = ST_HALTED;
                else                                 retire  = 1'b1;
            end
            ST_T4:   state_d = ST_T5;
            ST_T5: begin
                if (is_muldiv) state_d = ST_T6;
                else           retire  = 1'b1;
            end
            ST_T6:     retire  = 1'b1;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
        if (retire) state_d = run ? ST_T0 : ST_IDLE;
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes are decoded from state_q and ir rather than registered: the IR
    // loads on the edge that enters T3, so T3 decode cannot be precomputed.
    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowIn   = 1'b0;
        ZHighIn  = 1'b0;
        ZLowOut  = 1'b0;
        ZHighOut = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        alu_op   = '0;
        illegal  = 1'b0;
        rout_en  = 1'b0;
        rout_idx = rb;
        rin_en   = 1'b0;
        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
            end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (op_class == CL_ALU || is_muldiv) begin
                    rout_en = 1'b1;
                    Yin     = 1'b1;
                end
                illegal = (op_class == CL_ILLEGAL);
            end
            ST_T4: begin
                rout_en  = 1'b1;
                rout_idx = rc;
                ZLowIn   = 1'b1;
                ZHighIn  = is_muldiv;
                alu_op   = opcode;
            end
            ST_T5: begin
                ZLowOut = 1'b1;
                LOin    = is_muldiv;
                rin_en  = !is_muldiv;
            end
            ST_T6: begin
                ZHighOut = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    reg_select_decoder #(.NREGS(NREGS)) u_rout_dec (
        .idx_i    (rout_idx),
        .en_i     (rout_en),
        .onehot_o (Rout)
    );

    reg_select_decoder #(.NREGS(NREGS)) u_rin_dec (
        .idx_i    (ra),
        .en_i     (rin_en),
        .onehot_o (Rin)
    );

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign halted      = (state_q == ST_HALTED);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    import cpu_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] ir;
    logic        PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin;
    logic        ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin;
    logic [15:0] Rout, Rin;
    logic [4:0]  alu_op;
    logic        busy, halted, illegal;
    logic [15:0] instr_count;
    logic [13:0] strb_act;

    alu_sequencer #(.NREGS(16), .CNT_W(16)) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
        .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .LOin(LOin), .HIin(HIin),
        .Rout(Rout), .Rin(Rin), .alu_op(alu_op), .busy(busy), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    assign strb_act = {PCout, MARin, IncPC, Read, MDRin, MDRout, IRin,
                       Yin, ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin};

    localparam logic [13:0] S_PCOUT = 14'h2000, S_MARIN = 14'h1000, S_INCPC = 14'h0800;
    localparam logic [13:0] S_READ = 14'h0400, S_MDRIN = 14'h0200, S_MDROUT = 14'h0100;
    localparam logic [13:0] S_IRIN = 14'h0080, S_YIN = 14'h0040, S_ZLOWIN = 14'h0020;
    localparam logic [13:0] S_ZHIGHIN = 14'h0010, S_ZLOWOUT = 14'h0008, S_ZHIGHOUT = 14'h0004;
    localparam logic [13:0] S_LOIN = 14'h0002, S_HIIN = 14'h0001;

    typedef struct {
        string       tag;
        logic [13:0] strb;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  aluop;
        logic        ill;
        logic [15:0] cnt;
    } frame_t;

    typedef struct {
        logic [31:0] w;
        int          nw;
    } prog_t;

    frame_t      exp_q[$];
    prog_t       prog_q[$];
    logic [15:0] exp_cnt = '0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          first_busy = -1;
    int          last_busy = -1;
    int          wait_left = 0;
    logic [31:0] pend_w = '0;
    bit          run_force = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input string tag, input logic [13:0] strb, input logic [15:0] ro,
                              input logic [15:0] ri, input logic [4:0] op, input logic ill);
        frame_t f;
        f.tag = tag; f.strb = strb; f.rout = ro; f.rin = ri;
        f.aluop = op; f.ill = ill; f.cnt = exp_cnt;
        exp_q.push_back(f);
    endtask

    task automatic push_fetch(input string tag, input logic [31:0] w, input int nw);
        prog_t p;
        p.w = w; p.nw = nw;
        prog_q.push_back(p);
        push_frame({tag, ".T0"}, S_PCOUT | S_MARIN | S_INCPC, 16'h0, 16'h0, 5'd0, 1'b0);
        for (int i = 0; i <= nw; i++)
            push_frame({tag, ".T1"}, S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0, 1'b0);
        push_frame({tag, ".T2"}, S_MDROUT | S_IRIN, 16'h0, 16'h0, 5'd0, 1'b0);
    endtask

    task automatic issue_alu(input string tag, input logic [31:0] w, input int nw, input logic [4:0] op,
                             input logic [15:0] rb_oh, input logic [15:0] rc_oh, input logic [15:0] ra_oh);
        push_fetch(tag, w, nw);
        push_frame({tag, ".T3"}, S_YIN, rb_oh, 16'h0, 5'd0, 1'b0);
        push_frame({tag, ".T4"}, S_ZLOWIN, rc_oh, 16'h0, op, 1'b0);
        push_frame({tag, ".T5"}, S_ZLOWOUT, 16'h0, ra_oh, 5'd0, 1'b0);
        exp_cnt++;
    endtask

    task automatic issue_muldiv(input string tag, input logic [31:0] w, input int nw, input logic [4:0] op,
                                input logic [15:0] rb_oh, input logic [15:0] rc_oh);
        push_fetch(tag, w, nw);
        push_frame({tag, ".T3"}, S_YIN, rb_oh, 16'h0, 5'd0, 1'b0);
        push_frame({tag, ".T4"}, S_ZLOWIN | S_ZHIGHIN, rc_oh, 16'h0, op, 1'b0);
        push_frame({tag, ".T5"}, S_ZLOWOUT | S_LOIN, 16'h0, 16'h0, 5'd0, 1'b0);
        push_frame({tag, ".T6"}, S_ZHIGHOUT | S_HIIN, 16'h0, 16'h0, 5'd0, 1'b0);
        exp_cnt++;
    endtask

    task automatic issue_simple(input string tag, input logic [31:0] w, input int nw,
                                input logic ill, input bit retires);
        push_fetch(tag, w, nw);
        push_frame({tag, ".T3"}, 14'h0, 16'h0, 16'h0, 5'd0, ill);
        if (retires) exp_cnt++;
    endtask

    // Datapath/memory stand-in: supplies program words through IRin and
    // holds mem_ready low for the requested number of T1 cycles.
    always @(negedge clock) begin
        prog_t p;
        if (PCout && prog_q.size() > 0) begin
            p = prog_q.pop_front();
            pend_w = p.w;
            wait_left = p.nw;
        end
        if (Read && wait_left > 0) begin
            mem_ready = 1'b0;
            wait_left--;
        end else begin
            mem_ready = 1'b1;
        end
        if (IRin) ir = pend_w;
        run = run_force || (prog_q.size() > 0);
    end

    // Monitor: pops one expected frame for every busy cycle.
    always @(negedge clock) begin
        frame_t f;
        cyc++;
        if (!clear) begin
            check("rout_onehot0", 32'($onehot0(Rout)), 32'd1);
            check("rin_onehot0", 32'($onehot0(Rin)), 32'd1);
            check("rout_rin_excl", 32'((Rout != 16'h0) && (Rin != 16'h0)), 32'd0);
            if (busy) begin
                if (first_busy < 0) first_busy = cyc;
                last_busy = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_busy: busy=1 at cycle %0d, no frame expected", cyc);
                end else begin
                    f = exp_q.pop_front();
                    check({f.tag, ".strobes"}, strb_act, f.strb);
                    check({f.tag, ".Rout"}, Rout, f.rout);
                    check({f.tag, ".Rin"}, Rin, f.rin);
                    check({f.tag, ".alu_op"}, alu_op, f.aluop);
                    check({f.tag, ".illegal"}, illegal, f.ill);
                    check({f.tag, ".halted"}, halted, 1'b0);
                    check({f.tag, ".count"}, instr_count, f.cnt);
                end
            end else begin
                check("idle_quiet", {strb_act, alu_op, illegal}, 32'd0);
                check("idle_regsel", {Rout, Rin}, 32'd0);
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, ".strobes"}, strb_act, 32'd0);
        check({tag, ".regsel"}, {Rout, Rin}, 32'd0);
        check({tag, ".alu_op_ill"}, {alu_op, illegal}, 32'd0);
        check({tag, ".busy_halted"}, {busy, halted}, 32'd0);
        check({tag, ".count"}, instr_count, 32'd0);
    endtask

    task automatic finish_test(input string tag, input int span, input logic [15:0] cnt);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, ".done"}, {exp_q.size() != 0, busy}, 32'd0);
        check({tag, ".cycles"}, last_busy - first_busy + 1, span);
        check({tag, ".count"}, instr_count, cnt);
        exp_q.delete();
        #1 first_busy = -1;
    endtask

    initial begin
        int n;
        clear = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = '0;
        repeat (2) @(negedge clock);
        check_quiet("reset");
        #1 clear = 1'b0;

        issue_alu("and", 32'h2A1B8000, 0, OP_AND, 16'h0008, 16'h0080, 16'h0010);
        finish_test("and", 6, 16'd1);

        issue_muldiv("mul", 32'h78130000, 0, OP_MUL, 16'h0004, 16'h0040);
        finish_test("mul", 7, 16'd2);

        issue_alu("sub_wait", 32'h20928000, 3, OP_SUB, 16'h0004, 16'h0020, 16'h0002);
        finish_test("sub_wait", 9, 16'd3);

        issue_alu("b2b_and", 32'h2A1B8000, 0, OP_AND, 16'h0008, 16'h0080, 16'h0010);
        issue_muldiv("b2b_div", 32'h80448000, 1, OP_DIV, 16'h0100, 16'h0200);
        issue_simple("b2b_nop", 32'hD0000000, 0, 1'b0, 1'b1);
        finish_test("b2b", 18, 16'd6);

        issue_simple("ill", 32'hF8000000, 0, 1'b1, 1'b1);
        issue_simple("ill_nop", 32'hD0000000, 0, 1'b0, 1'b1);
        finish_test("ill", 8, 16'd8);

        issue_simple("halt", 32'hD8000000, 0, 1'b0, 1'b0);
        finish_test("halt", 4, 16'd8);
        check("halt.halted", halted, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_force = (i % 2 == 0);
            @(negedge clock);
            check("halt.hold", {halted, busy}, 32'd2);
        end
        #1 clear = 1'b1; run_force = 1'b0;
        exp_cnt = '0;
        @(negedge clock);
        check_quiet("halt_clear");
        #1 clear = 1'b0;

        issue_alu("abort", 32'h2A1B8000, 0, OP_AND, 16'h0008, 16'h0080, 16'h0010);
        n = 0;
        while (!ZLowIn && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("abort.reach_t4", ZLowIn, 1'b1);
        #1 clear = 1'b1;
        exp_q.delete(); prog_q.delete(); exp_cnt = '0;
        @(negedge clock);
        check_quiet("abort_clear");
        first_busy = -1;
        issue_alu("restart", 32'h20928000, 0, OP_SUB, 16'h0004, 16'h0020, 16'h0002);
        repeat (2) @(negedge clock);
        check("clear_beats_run", {busy, run}, 32'd1);
        #1 clear = 1'b0;
        finish_test("restart", 6, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
